// File: rtl/tpu_package.sv
// Shared TPU types and sizes: array dimension, weight address width, decoded
// instruction layout and the weight-load FSM encoding.
package tpu_package;

  localparam int MUL_SIZE   = 32;
  localparam int W_ADDR_W   = 16;
  localparam int DATA_W     = MUL_SIZE * 8;
  localparam int ROW_W      = $clog2(MUL_SIZE);
  localparam int DIM_W      = 16;
  localparam int TILE_CNT_W = 5;
  localparam int TILES_W    = DIM_W - ROW_W;
  localparam int MAXT_W     = 2 * TILES_W;

  typedef struct packed {
    logic [1:0]          MAC_op;
    logic [DIM_W-1:0]    U_dim;
    logic [DIM_W-1:0]    ITER_dim;
    logic [W_ADDR_W-1:0] weight_addr;
  } decoded_instr_t;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    WAIT_BUF = 4'b0010,
    FETCH    = 4'b0100,
    DRAIN    = 4'b1000
  } weight_load_states_t;

  // Tile count of a layer, given its dimensions already divided by MUL_SIZE.
  function automatic logic [MAXT_W-1:0] calc_max_tiles(input logic [TILES_W-1:0] u_tiles,
                                                       input logic [TILES_W-1:0] iter_tiles);
    return MAXT_W'(u_tiles) * MAXT_W'(iter_tiles);
  endfunction

endpackage

// File: rtl/weight_load_control_unit.sv
// Weight-load producer: streams MUL_SIZE-row weight tiles from weight memory into
// the MAC array's shadow bank and hands them to compute via the rdy/next handshake.
module weight_load_control_unit
  import tpu_package::*;
(
  input  logic                clk_i,
  input  logic                rstN_i,
  input  decoded_instr_t      instruction_i,
  input  logic                instruction_valid_i,
  input  logic                next_weight_tile_i,
  output logic                weight_mem_rd_en_o,
  output logic [W_ADDR_W-1:0] weight_mem_addr_o,
  input  logic [DATA_W-1:0]   weight_mem_data_i,
  output logic                weight_wr_en_o,
  output logic [ROW_W-1:0]    weight_wr_row_o,
  output logic [DATA_W-1:0]   weight_wr_data_o,
  output logic                shadow_sel_o,
  output logic                compute_weights_rdy_o,
  output logic                invalidate_instruction_o,
  output logic                underrun_err_o
);

  weight_load_states_t state_q, state_d;

  logic [W_ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
  logic [TILE_CNT_W-1:0] tile_cnt_q, tile_cnt_d;
  logic [TILES_W-1:0]    u_tiles_q, u_tiles_d;
  logic [TILES_W-1:0]    iter_tiles_q, iter_tiles_d;
  logic                  rdy_q, rdy_d;
  logic                  shadow_sel_q, shadow_sel_d;
  logic                  underrun_q, underrun_d;
  logic                  invalidate_q, invalidate_d;
  logic                  wr_vld_p1_q, wr_vld_p1_d;
  logic [ROW_W-1:0]      wr_row_p1_q, wr_row_p1_d;

  logic                  accept;
  logic [MAXT_W-1:0]     new_max_tiles;
  logic [MAXT_W-1:0]     cur_max_tiles;
  logic [TILE_CNT_W:0]   tile_inc;
  logic                  last_row;
  logic                  last_tile;
  logic                  consume;
  logic                  rd_en;

  // Dimension bits below one tile never affect the tile count.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction_i.MAC_op[0],
                               instruction_i.U_dim[ROW_W-1:0],
                               instruction_i.ITER_dim[ROW_W-1:0]};

  assign accept        = (state_q == IDLE) && instruction_valid_i && instruction_i.MAC_op[1];
  assign new_max_tiles = calc_max_tiles(instruction_i.U_dim[DIM_W-1:ROW_W],
                                        instruction_i.ITER_dim[DIM_W-1:ROW_W]);
  assign cur_max_tiles = calc_max_tiles(u_tiles_q, iter_tiles_q);
  assign tile_inc      = {1'b0, tile_cnt_q} + (TILE_CNT_W+1)'(1);
  assign last_row      = (row_cnt_q == ROW_W'(MUL_SIZE - 1));
  assign last_tile     = (MAXT_W'(tile_inc) == cur_max_tiles);
  assign consume       = next_weight_tile_i && rdy_q;

  // FSM state register
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept && (new_max_tiles != '0)) state_d = WAIT_BUF;
      WAIT_BUF: if (!rdy_q)                          state_d = FETCH;
      FETCH:    if (last_row)                        state_d = DRAIN;
      DRAIN:    state_d = last_tile ? IDLE : WAIT_BUF;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rd_en = (state_q == FETCH);
  end

  // Counters, handshake flags and the one-deep row write-back stage
  always_comb begin
    ptr_d        = ptr_q;
    row_cnt_d    = row_cnt_q;
    tile_cnt_d   = tile_cnt_q;
    u_tiles_d    = u_tiles_q;
    iter_tiles_d = iter_tiles_q;
    rdy_d        = rdy_q;
    shadow_sel_d = shadow_sel_q;
    underrun_d   = underrun_q;
    invalidate_d = accept;
    wr_vld_p1_d  = rd_en;
    wr_row_p1_d  = row_cnt_q;

    if (accept) begin
      u_tiles_d    = instruction_i.U_dim[DIM_W-1:ROW_W];
      iter_tiles_d = instruction_i.ITER_dim[DIM_W-1:ROW_W];
      ptr_d        = instruction_i.weight_addr;
      tile_cnt_d   = '0;
    end

    if ((state_q == WAIT_BUF) && !rdy_q) row_cnt_d = '0;

    if (state_q == FETCH) begin
      ptr_d     = ptr_q + W_ADDR_W'(1);
      row_cnt_d = row_cnt_q + ROW_W'(1);
    end

    if (state_q == DRAIN) begin
      tile_cnt_d = tile_inc[TILE_CNT_W-1:0];
      rdy_d      = 1'b1;
    end

    // rdy is never set and consumed on the same edge: DRAIN only runs with rdy low.
    if (consume) begin
      rdy_d        = 1'b0;
      shadow_sel_d = !shadow_sel_q;
    end

    if (next_weight_tile_i && !rdy_q) underrun_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      ptr_q        <= '0;
      row_cnt_q    <= '0;
      tile_cnt_q   <= '0;
      u_tiles_q    <= '0;
      iter_tiles_q <= '0;
      rdy_q        <= 1'b0;
      shadow_sel_q <= 1'b0;
      underrun_q   <= 1'b0;
      invalidate_q <= 1'b0;
      wr_vld_p1_q  <= 1'b0;
      wr_row_p1_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      row_cnt_q    <= row_cnt_d;
      tile_cnt_q   <= tile_cnt_d;
      u_tiles_q    <= u_tiles_d;
      iter_tiles_q <= iter_tiles_d;
      rdy_q        <= rdy_d;
      shadow_sel_q <= shadow_sel_d;
      underrun_q   <= underrun_d;
      invalidate_q <= invalidate_d;
      wr_vld_p1_q  <= wr_vld_p1_d;
      wr_row_p1_q  <= wr_row_p1_d;
    end
  end

  assign weight_mem_rd_en_o       = rd_en;
  assign weight_mem_addr_o        = ptr_q;
  assign weight_wr_en_o           = wr_vld_p1_q;
  assign weight_wr_row_o          = wr_row_p1_q;
  assign weight_wr_data_o         = weight_mem_data_i;
  assign shadow_sel_o             = shadow_sel_q;
  assign compute_weights_rdy_o    = rdy_q;
  assign invalidate_instruction_o = invalidate_q;
  assign underrun_err_o           = underrun_q;

endmodule
